dmem_bridge: RTL and testbench

Multi-cycle data-memory interface between the single-cycle MIPS datapath's load/store signals and a slower external data SRAM using a req/ack handshake. Converts the CPU's one-cycle access (address, store data, read/write strobes, b/h/w size) into byte-enabled word transactions. Raises a stall that freezes PC and register writes until the access completes. Returns lane-aligned load data to the existing load-extension path.

---
 rtl/dmem_bridge_if.sv | 33 +++
 rtl/dmem_bridge.sv | 176 +++++++++++++++++
 tb/tb_dmem_bridge.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_bridge_if.sv
// -----------------------------------------------------------------------------
// dmem_bridge_if
// Request/acknowledge bus between the data-memory bridge and the external
// data SRAM. The bridge (master) holds a word transaction until the memory
// (slave) acknowledges it; read data is valid in the acknowledge cycle.
//
//   mem_req   master->slave  transaction request, held until ack
//   mem_we    master->slave  1 = write
//   mem_addr  master->slave  word address
//   mem_wdata master->slave  lane-replicated write data
//   mem_be    master->slave  byte enables, bit i = byte i
//   mem_ack   slave->master  transaction complete
//   mem_rdata slave->master  read word, valid with mem_ack
// -----------------------------------------------------------------------------
interface dmem_bridge_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Turns the single-cycle datapath's load/store strobes into byte-enabled word
// transactions on a slow req/ack SRAM bus, stalling the CPU until the access
// finishes and returning load data aligned to bit 0 (zero-filled above).
//
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   cpu_addr   byte address          cpu_wdata  store data
//   cpu_mem_r  load strobe           cpu_mem_w  store strobe (wins over load)
//   cpu_size   00 word, 01 byte, 10 half, 11 word
//   cpu_rdata  lane-aligned load data, held until next completion/error
//   stall      CPU holds PC and suppresses writes while high
//   err        one-cycle pulse on misaligned access or timeout
//   mem        SRAM request/acknowledge bus (master side)
// -----------------------------------------------------------------------------
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic          cpu_mem_r,
    input  logic          cpu_mem_w,
    input  logic [1:0]    cpu_size,
    output logic [31:0]   cpu_rdata,
    output logic          stall,
    output logic          err,
    dmem_bridge_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [29:0]        addr_q, addr_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               we_q, we_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic        is_byte, is_half, aligned, access, launch, misalign, timeout_hit;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, rd_shift, lane_data;

    // Request decode: alignment, byte enables and replicated write data.
    always_comb begin
        is_byte = (cpu_size == 2'b01);
        is_half = (cpu_size == 2'b10);
        if (is_byte) begin
            aligned   = 1'b1;
            be_new    = 4'b0001 << cpu_addr[1:0];
            wdata_new = {4{cpu_wdata[7:0]}};
        end else if (is_half) begin
            aligned   = ~cpu_addr[0];
            be_new    = cpu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{cpu_wdata[15:0]}};
        end else begin
            aligned   = (cpu_addr[1:0] == 2'b00);
            be_new    = 4'b1111;
            wdata_new = cpu_wdata;
        end
        access      = cpu_mem_r | cpu_mem_w;
        launch      = (state_q == ST_IDLE) & access & aligned;
        misalign    = (state_q == ST_IDLE) & access & ~aligned;
        timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

    // Load lane extraction from the latched offset/size; half offsets are 0 or 2.
    always_comb begin
        rd_shift = mem.mem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'b01:   lane_data = {24'h0, rd_shift[7:0]};
            2'b10:   lane_data = {16'h0, rd_shift[15:0]};
            default: lane_data = mem.mem_rdata;
        endcase
    end

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a still-asserted
    // strobe from the committing instruction cannot relaunch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (launch) state_d = ST_REQ;
            ST_REQ:  if (mem.mem_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; ack takes priority over a coincident timeout.
    always_comb begin
        addr_d  = addr_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        if (launch) begin
            addr_d  = cpu_addr[31:2];
            off_d   = cpu_addr[1:0];
            size_d  = cpu_size;
            we_d    = cpu_mem_w;
            be_d    = be_new;
            wdata_d = wdata_new;
            cnt_d   = '0;
        end
        if (misalign) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end
        if (state_q == ST_REQ) begin
            if (mem.mem_ack) begin
                rdata_d = we_q ? 32'h0 : lane_data;
            end else if (timeout_hit) begin
                rdata_d = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs; stall is gated by reset so an abandoned access never stalls.
    always_comb begin
        stall       = rst & ((state_q == ST_REQ) | launch);
        mem.mem_req = (state_q == ST_REQ);
    end

    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;
    assign cpu_rdata     = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
// Directed accesses push expected bus requests and CPU responses into queues;
// independent monitors pop and compare when the DUT raises mem_req or ends a
// stall/pulses err. A small responder acknowledges after a programmed wait.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_mem_r, cpu_mem_w, stall, err;
    logic [1:0]  cpu_size;

    dmem_bridge_if mem_if ();

    dmem_bridge #(.TIMEOUT_CYC(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_mem_r (cpu_mem_r),
        .cpu_mem_w (cpu_mem_w),
        .cpu_size  (cpu_size),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .err       (err),
        .mem       (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stall_cycles;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int n_checks;
    int n_fail;
    int ack_wait;
    bit ack_en;
    bit force_ack;
    int rcyc;

    bit       b_prev_req;
    int       b_req_cnt;
    bit       b_have;
    bus_exp_t b_cur;

    bit       r_prev_stall;
    int       r_stall_cnt;
    rsp_exp_t r_cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bus(input logic we, input logic [29:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input int reqc);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.req_cycles = reqc;
        bus_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [31:0] rdata, input logic e_err, input int stallc);
        rsp_exp_t e;
        e.rdata = rdata; e.err = e_err; e.stall_cycles = stallc;
        rsp_q.push_back(e);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_mem_req"},   32'(mem_if.mem_req), 32'h0);
        chk({tag, "_mem_we"},    32'(mem_if.mem_we), 32'h0);
        chk({tag, "_mem_addr"},  32'(mem_if.mem_addr), 32'h0);
        chk({tag, "_mem_wdata"}, mem_if.mem_wdata, 32'h0);
        chk({tag, "_mem_be"},    32'(mem_if.mem_be), 32'h0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        chk({tag, "_err"},       32'(err), 32'h0);
        chk({tag, "_stall"},     32'(stall), 32'h0);
    endtask

    // Present one access, wait (bounded) until the stall is released, then drop it.
    task automatic run_access(input logic r, input logic w, input logic [1:0] sz,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] mrdata, input int wt, input bit en);
        bit done;
        @(posedge clk); #1;
        cpu_mem_r = r; cpu_mem_w = w; cpu_size = sz; cpu_addr = addr; cpu_wdata = wdata;
        mem_if.mem_rdata = mrdata; ack_wait = wt; ack_en = en;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        chk("access_completes", 32'(done), 32'h1);
        @(posedge clk); #1;
        cpu_mem_r = 1'b0; cpu_mem_w = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Memory responder: ack in REQ cycle ack_wait+1, or any time force_ack is set.
    initial begin
        mem_if.mem_ack = 1'b0;
        rcyc = 0;
        forever begin
            @(negedge clk);
            if (mem_if.mem_req) begin
                rcyc++;
                mem_if.mem_ack = force_ack || (ack_en && (rcyc == ack_wait + 1));
            end else begin
                rcyc = 0;
                mem_if.mem_ack = force_ack;
            end
        end
    end

    // Bus monitor.
    initial begin
        b_prev_req = 1'b0; b_req_cnt = 0; b_have = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.mem_req && !b_prev_req) begin
                b_req_cnt = 1;
                if (bus_q.size() == 0) begin
                    n_checks++; n_fail++; b_have = 1'b0;
                    $display("FAIL bus_unexpected: mem_req rose with addr 0x%08h, none expected",
                             32'(mem_if.mem_addr));
                end else begin
                    b_cur = bus_q.pop_front(); b_have = 1'b1;
                    chk("bus_we",    32'(mem_if.mem_we),   32'(b_cur.we));
                    chk("bus_addr",  32'(mem_if.mem_addr), 32'(b_cur.addr));
                    chk("bus_be",    32'(mem_if.mem_be),   32'(b_cur.be));
                    chk("bus_wdata", mem_if.mem_wdata,     b_cur.wdata);
                end
            end else if (mem_if.mem_req) begin
                b_req_cnt++;
                if (b_have) begin
                    chk("bus_addr_stable",  32'(mem_if.mem_addr), 32'(b_cur.addr));
                    chk("bus_wdata_stable", mem_if.mem_wdata,     b_cur.wdata);
                end
            end else if (b_prev_req && b_have) begin
                chk("bus_req_cycles", 32'(b_req_cnt), 32'(b_cur.req_cycles));
                b_have = 1'b0;
            end
            b_prev_req = mem_if.mem_req;
        end
    end

    // CPU response monitor: an event is a stall release or an err pulse.
    initial begin
        r_prev_stall = 1'b0; r_stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                r_prev_stall = 1'b0;
                r_stall_cnt  = 0;
            end else begin
                if (stall) begin
                    r_stall_cnt++;
                end else if (r_prev_stall || err) begin
                    if (rsp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rsp_unexpected: rdata 0x%08h err %0b, none expected",
                                 cpu_rdata, err);
                    end else begin
                        r_cur = rsp_q.pop_front();
                        chk("rsp_rdata",        cpu_rdata,          r_cur.rdata);
                        chk("rsp_err",          32'(err),           32'(r_cur.err));
                        chk("rsp_stall_cycles", 32'(r_stall_cnt),   32'(r_cur.stall_cycles));
                    end
                    r_stall_cnt = 0;
                end
                r_prev_stall = stall;
            end
        end
    end

    initial begin
        n_checks = 0; n_fail = 0;
        ack_wait = 0; ack_en = 1'b0; force_ack = 1'b0;
        rst = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_mem_r = 1'b0; cpu_mem_w = 1'b0; cpu_size = 2'b00;
        mem_if.mem_rdata = '0;
        #12;
        chk_reset_state("por");
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);

        // Word load, ack in first REQ cycle.
        push_bus(1'b0, 30'h4, 4'b1111, 32'h1122_3344, 1);
        push_rsp(32'hDEAD_BEEF, 1'b0, 2);
        run_access(1'b1, 1'b0, 2'b00, 32'h10, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1'b1);

        // Byte store to lane 3, three wait cycles (ack coincides with last counter value).
        push_bus(1'b1, 30'h4, 4'b1000, 32'hA5A5_A5A5, 4);
        push_rsp(32'h0, 1'b0, 5);
        run_access(1'b0, 1'b1, 2'b01, 32'h13, 32'h0000_00A5, 32'hFFFF_FFFF, 3, 1'b1);

        // Upper half load, one wait cycle.
        push_bus(1'b0, 30'h1, 4'b1100, 32'h0, 2);
        push_rsp(32'h0000_1234, 1'b0, 3);
        run_access(1'b1, 1'b0, 2'b10, 32'h6, 32'h0, 32'h1234_8765, 1, 1'b1);

        // Misaligned word load: no request, err pulse, rdata cleared.
        push_rsp(32'h0, 1'b1, 0);
        run_access(1'b1, 1'b0, 2'b00, 32'h2, 32'h0, 32'h5555_5555, 0, 1'b1);

        // Byte load from lane 1.
        push_bus(1'b0, 30'h8, 4'b0010, 32'hFFFF_FFFF, 1);
        push_rsp(32'h0000_00BA, 1'b0, 2);
        run_access(1'b1, 1'b0, 2'b01, 32'h21, 32'h0000_00FF, 32'hCAFE_BABE, 0, 1'b1);

        // Load and store strobes together: store wins, lower half.
        push_bus(1'b1, 30'h2, 4'b0011, 32'hBEEF_BEEF, 1);
        push_rsp(32'h0, 1'b0, 2);
        run_access(1'b1, 1'b1, 2'b10, 32'h8, 32'h0000_BEEF, 32'h7777_7777, 0, 1'b1);

        // Upper half store at addr[1]=1.
        push_bus(1'b1, 30'h0, 4'b1100, 32'h5678_5678, 2);
        push_rsp(32'h0, 1'b0, 3);
        run_access(1'b0, 1'b1, 2'b10, 32'h2, 32'h1234_5678, 32'h0, 1, 1'b1);

        // Word load returning data, so the timeout below must clear it.
        push_bus(1'b0, 30'h3, 4'b1111, 32'h0, 1);
        push_rsp(32'h0F0F_1234, 1'b0, 2);
        run_access(1'b1, 1'b0, 2'b00, 32'hC, 32'h0, 32'h0F0F_1234, 0, 1'b1);

        // Timeout: no ack, mem_req for TIMEOUT_CYC cycles, err in DONE.
        push_bus(1'b0, 30'h10, 4'b1111, 32'h0, 4);
        push_rsp(32'h0, 1'b1, 5);
        run_access(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 32'h9999_9999, 0, 1'b0);

        // Late ack while idle must be ignored.
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rdata", cpu_rdata, 32'h0);
        chk("late_ack_req",   32'(mem_if.mem_req), 32'h0);
        chk("late_ack_stall", 32'(stall), 32'h0);
        @(posedge clk);

        // Misaligned half store is dropped.
        push_rsp(32'h0, 1'b1, 0);
        run_access(1'b0, 1'b1, 2'b10, 32'h5, 32'hFFFF_FFFF, 32'h0, 0, 1'b1);

        // Size 11 behaves as word.
        push_bus(1'b0, 30'h3, 4'b1111, 32'h0, 1);
        push_rsp(32'h55AA_55AA, 1'b0, 2);
        run_access(1'b1, 1'b0, 2'b11, 32'hC, 32'h0, 32'h55AA_55AA, 0, 1'b1);

        // Reset during the second REQ cycle abandons the transaction.
        push_bus(1'b0, 30'h40, 4'b1111, 32'h0, 1);
        @(posedge clk); #1;
        cpu_mem_r = 1'b1; cpu_mem_w = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h100;
        cpu_wdata = 32'h0; ack_en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_req_mem_req", 32'(mem_if.mem_req), 32'h0);
        chk("rst_mid_req_stall",   32'(stall), 32'h0);
        cpu_mem_r = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state("in_reset");
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("after_release");

        push_bus(1'b0, 30'h40, 4'b1111, 32'h0, 3);
        push_rsp(32'h0BAD_F00D, 1'b0, 4);
        run_access(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 32'h0BAD_F00D, 2, 1'b1);

        repeat (4) @(posedge clk);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
